// File: rtl/alu_pkg.sv
// Shared RV32I ALU encodings (opcodes, funct3, alternate funct7) and the arbiter's response-slot state.
package alu_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_t;

endpackage

// File: rtl/alu.sv
// Shared combinational RV32I integer ALU for OP and OP-IMM; any other opcode yields 0.
module alu
    import alu_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [11:0] imm,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] result
);

    logic [31:0] operandB;
    logic        isAlt;
    logic [4:0]  shamt;

    always_comb begin
        operandB = (opcode == OP_IMM) ? {{20{imm[11]}}, imm} : rs2;
        // For OP-IMM the alternate-operation marker lives in imm[11:5]
        isAlt    = (opcode == OP_IMM) ? (imm[11:5] == F7_ALT) : (funct7 == F7_ALT);
        shamt    = operandB[4:0];
        result   = '0;
        if ((opcode == OP) || (opcode == OP_IMM)) begin
            case (funct3)
                F3_ADD: begin
                    if ((opcode == OP) && isAlt) result = rs1 - operandB;
                    else                         result = rs1 + operandB;
                end
                F3_SLL:  result = rs1 << shamt;
                F3_SLT:  result = {31'b0, $signed(rs1) < $signed(operandB)};
                F3_SLTU: result = {31'b0, rs1 < operandB};
                F3_XOR:  result = rs1 ^ operandB;
                F3_SR: begin
                    if (isAlt) result = $signed(rs1) >>> shamt;
                    else       result = rs1 >> shamt;
                end
                F3_OR:   result = rs1 | operandB;
                F3_AND:  result = rs1 & operandB;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one RV32I ALU among NUM_REQ requesters with a single registered response slot.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [7*NUM_REQ-1:0]    req_opcode,
    input  logic [3*NUM_REQ-1:0]    req_funct3,
    input  logic [7*NUM_REQ-1:0]    req_funct7,
    input  logic [12*NUM_REQ-1:0]   req_imm,
    input  logic [32*NUM_REQ-1:0]   req_rs1,
    input  logic [32*NUM_REQ-1:0]   req_rs2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result
);

    logic [6:0]  opcodeArr [NUM_REQ];
    logic [2:0]  funct3Arr [NUM_REQ];
    logic [6:0]  funct7Arr [NUM_REQ];
    logic [11:0] immArr    [NUM_REQ];
    logic [31:0] rs1Arr    [NUM_REQ];
    logic [31:0] rs2Arr    [NUM_REQ];

    slotState_t      stateReg, stateNext;
    logic [ID_W-1:0] rrPtr;
    logic [ID_W-1:0] grantIdx;
    logic [ID_W-1:0] scanSel;
    logic            grantFound;
    logic            canAccept;
    logic            transfer;
    int              scanIdx;
    logic [31:0]     aluResult;
    logic [ID_W-1:0] rspIdReg;
    logic [31:0]     rspResultReg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gReq
            assign opcodeArr[gi] = req_opcode[7*gi +: 7];
            assign funct3Arr[gi] = req_funct3[3*gi +: 3];
            assign funct7Arr[gi] = req_funct7[7*gi +: 7];
            assign immArr[gi]    = req_imm[12*gi +: 12];
            assign rs1Arr[gi]    = req_rs1[32*gi +: 32];
            assign rs2Arr[gi]    = req_rs2[32*gi +: 32];
            // Ready is forced low while reset is held, even though the slot already reads EMPTY
            assign req_ready[gi] = rst_n && canAccept && grantFound && (grantIdx == ID_W'(gi));
        end
    endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rrPtr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (transfer) begin
            rrPtr <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
        end
    end
`endif

    always_comb begin
        grantIdx   = '0;
        grantFound = 1'b0;
        scanIdx    = 0;
        scanSel    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scanIdx = int'(rrPtr) + off;
            if (scanIdx >= NUM_REQ) scanIdx = scanIdx - NUM_REQ;
            scanSel = ID_W'(scanIdx);
            if (!grantFound && req_valid[scanSel]) begin
                grantFound = 1'b1;
                grantIdx   = scanSel;
            end
        end
    end

    assign canAccept = (stateReg == EMPTY) || rsp_ready;
    assign transfer  = |(req_valid & req_ready);

    alu u_alu (
        .opcode (opcodeArr[grantIdx]),
        .funct3 (funct3Arr[grantIdx]),
        .funct7 (funct7Arr[grantIdx]),
        .imm    (immArr[grantIdx]),
        .rs1    (rs1Arr[grantIdx]),
        .rs2    (rs2Arr[grantIdx]),
        .result (aluResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateReg <= EMPTY;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            EMPTY:   if (transfer) stateNext = FULL;
            FULL: begin
                if (transfer)       stateNext = FULL;
                else if (rsp_ready) stateNext = EMPTY;
            end
            default: stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspIdReg     <= '0;
            rspResultReg <= '0;
        end else if (transfer) begin
            rspIdReg     <= grantIdx;
            rspResultReg <= aluResult;
        end
    end

    assign rsp_valid  = (stateReg == FULL);
    assign rsp_id     = rspIdReg;
    assign rsp_result = rspResultReg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal expectations plus randomized traffic vs a queue-free behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 2;
    localparam int ID_W = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rspReady = 1'b0;
    logic [N-1:0]    vld = '0;
    logic [6:0]      opc [N];
    logic [2:0]      f3  [N];
    logic [6:0]      f7  [N];
    logic [11:0]     imm [N];
    logic [31:0]     a   [N];
    logic [31:0]     b   [N];

    logic [7*N-1:0]  opcBus, f7Bus;
    logic [3*N-1:0]  f3Bus;
    logic [12*N-1:0] immBus;
    logic [32*N-1:0] aBus, bBus;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        opcBus = '0; f3Bus = '0; f7Bus = '0; immBus = '0; aBus = '0; bBus = '0;
        for (int i = 0; i < N; i++) begin
            opcBus[7*i +: 7]  = opc[i];
            f3Bus[3*i +: 3]   = f3[i];
            f7Bus[7*i +: 7]   = f7[i];
            immBus[12*i +: 12] = imm[i];
            aBus[32*i +: 32]  = a[i];
            bBus[32*i +: 32]  = b[i];
        end
    end

    alu_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (vld),
        .req_ready  (req_ready),
        .req_opcode (opcBus),
        .req_funct3 (f3Bus),
        .req_funct7 (f7Bus),
        .req_imm    (immBus),
        .req_rs1    (aBus),
        .req_rs2    (bBus),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rspReady),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference RV32I result from instruction semantics
    function automatic logic [31:0] refAlu(input logic [6:0] o, input logic [2:0] fn3,
                                           input logic [6:0] fn7, input logic [11:0] im,
                                           input logic [31:0] x, input logic [31:0] rb);
        logic [31:0] y;
        logic [4:0]  sh;
        logic        alt;
        logic        isImm;
        if (o != OP && o != OP_IMM) return 32'd0;
        isImm = (o == OP_IMM);
        y     = isImm ? {{20{im[11]}}, im} : rb;
        alt   = isImm ? (im[11:5] == 7'b0100000) : (fn7 == 7'b0100000);
        sh    = y[4:0];
        case (fn3)
            3'd0: return (!isImm && alt) ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? ((x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)) : (x >> sh);
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Behavioural model + per-cycle compare
    initial begin : compare
        int          mPtr, nPtr, g, idx;
        logic        mFull, nFull, canAcc;
        logic [31:0] mId, nId, mRes, nRes;
        logic [N-1:0] expReady;
        mPtr = 0; mFull = 1'b0; mId = 0; mRes = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mPtr = 0; mFull = 1'b0; mId = 0; mRes = 0;
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
            canAcc   = rst_n && (!mFull || rspReady);
            expReady = '0;
            if (g >= 0 && canAcc) expReady[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(expReady));
            check("rsp_valid", 32'(rsp_valid), 32'(mFull));
            if (mFull) begin
                check("rsp_id", 32'(rsp_id), mId);
                check("rsp_result", rsp_result, mRes);
            end
            if (!rst_n) check("rsp_result_in_reset", rsp_result, 32'd0);
            nPtr = mPtr; nFull = mFull; nId = mId; nRes = mRes;
            if (g >= 0 && canAcc) begin
                nFull = 1'b1;
                nId   = 32'(g);
                nRes  = refAlu(opc[g], f3[g], f7[g], imm[g], a[g], b[g]);
                nPtr  = FIXED ? 0 : (g + 1) % N;
            end else if (rspReady) begin
                nFull = 1'b0;
            end
            @(posedge clk);
            if (!rst_n) begin
                mPtr = 0; mFull = 1'b0; mId = 0; mRes = 0;
            end else begin
                if (g >= 0 && canAcc)
                    $display("[TB] t=%0t accept req%0d -> result 0x%08h", $time, nId, nRes);
                mPtr = nPtr; mFull = nFull; mId = nId; mRes = nRes;
            end
        end
    end

    task automatic setReq(input int i, input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                          input logic [11:0] im, input logic [31:0] x, input logic [31:0] y);
        vld[i] = 1'b1; opc[i] = o; f3[i] = fn3; f7[i] = fn7; imm[i] = im; a[i] = x; b[i] = y;
    endtask

    task automatic randReq(input int i);
        logic [31:0] edges [4];
        int r;
        edges[0] = 32'h0; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000; edges[3] = 32'h7FFF_FFFF;
        r = $urandom_range(0, 9);
        opc[i] = (r < 4) ? OP : (r < 8) ? OP_IMM : 7'($urandom);
        f3[i]  = 3'($urandom);
        r = $urandom_range(0, 2);
        f7[i]  = (r == 0) ? 7'b0 : (r == 1) ? F7_ALT : 7'($urandom);
        imm[i] = 12'($urandom);
        if ($urandom_range(0, 3) == 0) imm[i][11:5] = F7_ALT;
        a[i] = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
        b[i] = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
        vld[i] = 1'b1;
    endtask

    task automatic toPosedge();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) begin
            opc[i] = '0; f3[i] = '0; f7[i] = '0; imm[i] = '0; a[i] = '0; b[i] = '0;
        end
        #1 rst_n = 1'b0;

        // Reset with every requester valid
        setReq(0, OP_IMM, F3_ADD, 7'd0, 12'd5, 32'd10, 32'd0);
        setReq(1, OP, F3_ADD, F7_ALT, 12'd0, 32'd7, 32'd3);
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // ADDI on req0
        toPosedge();
        rst_n = 1'b1; rspReady = 1'b1; vld = '0;
        setReq(0, OP_IMM, F3_ADD, 7'd0, 12'd5, 32'd10, 32'd0);
        @(negedge clk);
        check("addi_ready", 32'(req_ready), 32'd1);
        toPosedge();
        vld[0] = 1'b0;
        setReq(1, OP, F3_ADD, F7_ALT, 12'd0, 32'd7, 32'd3);
        @(negedge clk);
        check("addi_valid", 32'(rsp_valid), 32'd1);
        check("addi_id", 32'(rsp_id), 32'd0);
        check("addi_result", rsp_result, 32'd15);
        check("sub_ready", 32'(req_ready), 32'd2);
        toPosedge();
        vld = '0;
        @(negedge clk);
        check("sub_id", 32'(rsp_id), 32'd1);
        check("sub_result", rsp_result, 32'd4);

        // Fairness: both valid continuously
        toPosedge();
        setReq(0, OP, F3_ADD, 7'd0, 12'd0, 32'd100, 32'd23);
        setReq(1, OP, F3_XOR, 7'd0, 12'd0, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int k = 0; k < 4; k++) begin
            toPosedge();
            if (k == 3) vld = '0;
            @(negedge clk);
            check("fair_id", 32'(rsp_id), (FIXED || k % 2 == 0) ? 32'd0 : 32'd1);
            check("fair_result", rsp_result, (FIXED || k % 2 == 0) ? 32'd123 : 32'h0000_FF00);
        end

        // Backpressure
        toPosedge();
        setReq(0, OP, F3_ADD, 7'd0, 12'd0, 32'd5, 32'd6);
        setReq(1, OP, F3_AND, 7'd0, 12'd0, 32'hFF, 32'h0F);
        @(negedge clk);
        check("bp_first_ready", 32'(req_ready), 32'd1);
        toPosedge();
        rspReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_hold_result", rsp_result, 32'd11);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        toPosedge();
        rspReady = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), FIXED ? 32'd1 : 32'd2);
        toPosedge();
        vld = '0;
        @(negedge clk);
        check("bp_next_id", 32'(rsp_id), FIXED ? 32'd0 : 32'd1);
        check("bp_next_result", rsp_result, FIXED ? 32'd11 : 32'h0F);

        // Reset while a result is held
        toPosedge();
        rspReady = 1'b0;
        setReq(0, OP, F3_ADD, 7'd0, 12'd0, 32'd1, 32'd1);
        @(negedge clk);
        check("midrst_ready", 32'(req_ready), 32'd1);
        toPosedge();
        vld = '0;
        @(negedge clk);
        check("midrst_held", rsp_result, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_drop", 32'(rsp_valid), 32'd0);
        check("midrst_result_clr", rsp_result, 32'd0);
        toPosedge();
        rst_n = 1'b1; rspReady = 1'b1;
        setReq(0, OP_IMM, F3_OR, 7'd0, 12'h0F0, 32'h1, 32'd0);
        setReq(1, OP, F3_SLT, 7'd0, 12'd0, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("midrst_ptr_zero", 32'(req_ready), 32'd1);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = vld & req_ready;
            toPosedge();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 1) == 0) vld[i] = 1'b0;
                    else randReq(i);
                end else if (!vld[i] && $urandom_range(0, 2) != 0) begin
                    randReq(i);
                end
            end
            rspReady = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 599) != 0);
        end
        toPosedge();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
